oehb_nslot: RTL and testbench

Parametrised multi-slot opaque elastic buffer for handshake dataflow circuits. It stores up to NUM_SLOTS tokens in a circular buffer and cuts both the valid/data path and the ready path, so no combinational path runs from input to output in either direction. It sits where the single-slot opaque buffer sat on long or throughput-critical channels.

---
 rtl/oehb_pkg.sv | 16 +
 rtl/oehb_nslot_dataless.sv | 73 +++++++
 rtl/oehb_nslot.sv | 61 ++++++
 tb/tb_oehb_nslot.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oehb_pkg.sv
// Shared sizing helpers for the multi-slot opaque elastic buffer.
package oehb_pkg;

    localparam int OEHB_MAX_SLOTS = 4096;

    function automatic int ptr_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/oehb_nslot_dataless.sv
// Control half of oehb_nslot: circular-buffer pointers, token count and handshake flags.
// Exposes the count when OEHB_NSLOT_OCCUPANCY_EN is defined.
module oehb_nslot_dataless
    import oehb_pkg::*;
#(
    parameter  int NUM_SLOTS = 2,
    localparam int PTR_W     = ptr_width(NUM_SLOTS),
    localparam int CNT_W     = cnt_width(NUM_SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    output logic             ins_ready,
    output logic             outs_valid,
    input  logic             outs_ready,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [PTR_W-1:0] rd_addr
`ifdef OEHB_NSLOT_OCCUPANCY_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    if (NUM_SLOTS < 1 || NUM_SLOTS > OEHB_MAX_SLOTS) begin : g_bad_num_slots
        $error("oehb_nslot: NUM_SLOTS out of supported range");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly so NUM_SLOTS need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ins_ready  = (cnt != CNT_W'(NUM_SLOTS));
    assign outs_valid = (cnt != '0);
    assign push       = ins_valid & ins_ready;
    assign pop        = outs_valid & outs_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign wr_en   = push;
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;

`ifdef OEHB_NSLOT_OCCUPANCY_EN
    assign count = cnt;
`endif

endmodule

// File: rtl/oehb_nslot.sv
// Multi-slot opaque elastic buffer: registered valid/data and ready, FIFO order, no bypass.
// Optional occupancy output enabled by defining OEHB_NSLOT_OCCUPANCY_EN.
module oehb_nslot
    import oehb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_SLOTS  = 2,
    localparam int PTR_W      = ptr_width(NUM_SLOTS),
    localparam int CNT_W      = cnt_width(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef OEHB_NSLOT_OCCUPANCY_EN
    ,
    output logic [CNT_W-1:0]      occupancy
`endif
);

    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_addr;
    logic [PTR_W-1:0]      rd_addr;

    oehb_nslot_dataless #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr)
`ifdef OEHB_NSLOT_OCCUPANCY_EN
        ,
        .count      (occupancy)
`endif
    );

    // Storage is cleared on reset so outs reads 0 until the first token lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= ins;
        end
    end

    assign outs = mem[rd_addr];

endmodule

// File: tb/tb_oehb_nslot.sv
// Bench for oehb_nslot: four instances (4/2/3/1 slots) checked against a queue scoreboard.
module tb_oehb_nslot;

    localparam int NDUT = 4;
    localparam int DW   = 8;

    function automatic int ns_of(input int g);
        case (g)
            0:       return 4;
            1:       return 2;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          ins_valid  [NDUT];
    logic          outs_ready [NDUT];
    logic          ins_ready  [NDUT];
    logic          outs_valid [NDUT];
    logic [DW-1:0] ins        [NDUT];
    logic [DW-1:0] outs       [NDUT];
`ifdef OEHB_NSLOT_OCCUPANCY_EN
    logic [2:0]    occ        [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int NS = ns_of(g);
`ifdef OEHB_NSLOT_OCCUPANCY_EN
        logic [$clog2(NS+1)-1:0] occ_l;
        assign occ[g] = 3'(occ_l);
`endif
        oehb_nslot #(.DATA_WIDTH(DW), .NUM_SLOTS(NS)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .ins        (ins[g]),
            .ins_valid  (ins_valid[g]),
            .ins_ready  (ins_ready[g]),
            .outs       (outs[g]),
            .outs_valid (outs_valid[g]),
            .outs_ready (outs_ready[g])
`ifdef OEHB_NSLOT_OCCUPANCY_EN
            ,
            .occupancy  (occ_l)
`endif
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted tokens queue up per instance; the model decides acceptance itself.
    typedef logic [DW-1:0] q_t[$];
    q_t sbq [NDUT];
    int push_cnt [NDUT];
    int pop_cnt  [NDUT];
    bit mon_en = 1'b0;

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            push_cnt[g] = 0;
            pop_cnt[g]  = 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NDUT; g++) sbq[g].delete();
        end else begin
            for (int g = 0; g < NDUT; g++) begin
                if (ins_valid[g] && sbq[g].size() != ns_of(g)) begin
                    if (outs_ready[g] && sbq[g].size() != 0) begin
                        void'(sbq[g].pop_front());
                        pop_cnt[g] <= pop_cnt[g] + 1;
                    end
                    sbq[g].push_back(ins[g]);
                    push_cnt[g] <= push_cnt[g] + 1;
                end else if (outs_ready[g] && sbq[g].size() != 0) begin
                    void'(sbq[g].pop_front());
                    pop_cnt[g] <= pop_cnt[g] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int g = 0; g < NDUT; g++) begin
                check($sformatf("d%0d_ins_ready", g), ins_ready[g], sbq[g].size() != ns_of(g));
                check($sformatf("d%0d_outs_valid", g), outs_valid[g], sbq[g].size() != 0);
                if (sbq[g].size() != 0)
                    check($sformatf("d%0d_outs_order", g), outs[g], sbq[g][0]);
`ifdef OEHB_NSLOT_OCCUPANCY_EN
                check($sformatf("d%0d_occupancy", g), occ[g], sbq[g].size());
`endif
            end
        end
    end

    typedef struct {
        logic          v;
        logic          r;
        logic [DW-1:0] d;
        logic          e_rdy;
        logic          e_vld;
        logic [DW-1:0] e_out;
        logic [2:0]    e_occ;
    } vec_t;

    initial begin
        vec_t tbl [9];
        int   p0, u0, k;

        tbl[0] = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b1, 8'hA1, 3'd1};
        tbl[1] = '{1'b1, 1'b0, 8'hA2, 1'b1, 1'b1, 8'hA1, 3'd2};
        tbl[2] = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 8'hA1, 3'd3};
        tbl[3] = '{1'b1, 1'b0, 8'hA4, 1'b0, 1'b1, 8'hA1, 3'd4};
        tbl[4] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA1, 3'd4};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA2, 3'd3};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA3, 3'd2};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA4, 3'd1};
        tbl[8] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0};

        for (int g = 0; g < NDUT; g++) begin
            ins_valid[g]  = 1'b0;
            outs_ready[g] = 1'b0;
            ins[g]        = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                check($sformatf("idle_d%0d_outs_valid", g), outs_valid[g], 1'b0);
                check($sformatf("idle_d%0d_ins_ready", g), ins_ready[g], 1'b1);
                check($sformatf("idle_d%0d_outs", g), outs[g], 8'h00);
`ifdef OEHB_NSLOT_OCCUPANCY_EN
                check($sformatf("idle_d%0d_occupancy", g), occ[g], 3'd0);
`endif
            end
        end
        mon_en = 1'b1;

        // Fill / block / drain on the 4-slot instance
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ins_valid[0]  = tbl[i].v;
            outs_ready[0] = tbl[i].r;
            ins[0]        = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_ins_ready", i), ins_ready[0], tbl[i].e_rdy);
            check($sformatf("tbl%0d_outs_valid", i), outs_valid[0], tbl[i].e_vld);
            if (tbl[i].e_vld)
                check($sformatf("tbl%0d_outs", i), outs[0], tbl[i].e_out);
`ifdef OEHB_NSLOT_OCCUPANCY_EN
            check($sformatf("tbl%0d_occupancy", i), occ[0], tbl[i].e_occ);
`endif
        end
        @(negedge clk);
        ins_valid[0]  = 1'b0;
        outs_ready[0] = 1'b0;

        // Streaming on the 2-slot instance
        p0 = pop_cnt[1];
        for (int c = 0; c < 20; c++) begin
            ins_valid[1]  = 1'b1;
            outs_ready[1] = 1'b1;
            ins[1]        = 8'(8'h10 + c);
            @(negedge clk);
            check($sformatf("stream%0d_outs_valid", c), outs_valid[1], 1'b1);
            check($sformatf("stream%0d_outs", c), outs[1], 8'(8'h10 + c));
            check($sformatf("stream%0d_pops", c), pop_cnt[1] - p0, c);
        end
        ins_valid[1] = 1'b0;
        @(negedge clk);
        outs_ready[1] = 1'b0;

        // Wrap-around with random backpressure on the 3-slot instance
        u0 = push_cnt[2];
        p0 = pop_cnt[2];
        for (int cyc = 0; cyc < 200 && (pop_cnt[2] - p0) < 10; cyc++) begin
            k = push_cnt[2] - u0;
            ins_valid[2]  = (k < 10);
            ins[2]        = 8'(k * 37 + 5);
            outs_ready[2] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        ins_valid[2]  = 1'b0;
        outs_ready[2] = 1'b0;
        check("wrap_pushes", push_cnt[2] - u0, 10);
        check("wrap_pops", pop_cnt[2] - p0, 10);

        // Single slot: one token every other cycle
        u0 = push_cnt[3];
        p0 = pop_cnt[3];
        for (int c = 0; c < 10; c++) begin
            ins_valid[3]  = 1'b1;
            outs_ready[3] = 1'b1;
            ins[3]        = 8'(8'h30 + c);
            @(negedge clk);
        end
        check("ns1_pushes", push_cnt[3] - u0, 5);
        check("ns1_pops", pop_cnt[3] - p0, 5);
        outs_ready[3] = 1'b0;
        ins[3]        = 8'h3F;
        @(negedge clk);
        ins_valid[3]  = 1'b0;
        outs_ready[3] = 1'b1;
        #1;
        check("ns1_ready_indep_hi", ins_ready[3], 1'b0);
        outs_ready[3] = 1'b0;
        #1;
        check("ns1_ready_indep_lo", ins_ready[3], 1'b0);
        @(negedge clk);
        outs_ready[3] = 1'b1;
        @(negedge clk);
        outs_ready[3] = 1'b0;

        // Reset with two tokens stored, then a fresh token
        ins_valid[0] = 1'b1;
        ins[0]       = 8'h11;
        @(negedge clk);
        ins[0] = 8'h22;
        @(negedge clk);
        ins[0] = 8'h99;
        #2;
        rst = 1'b1;
        #1;
        check("rst_outs_valid", outs_valid[0], 1'b0);
        check("rst_ins_ready", ins_ready[0], 1'b1);
        check("rst_outs", outs[0], 8'h00);
`ifdef OEHB_NSLOT_OCCUPANCY_EN
        check("rst_occupancy", occ[0], 3'd0);
`endif
        @(negedge clk);
        rst    = 1'b0;
        ins[0] = 8'h55;
        @(posedge clk);
        #1;
        check("post_rst_outs_valid", outs_valid[0], 1'b1);
        check("post_rst_outs", outs[0], 8'h55);
`ifdef OEHB_NSLOT_OCCUPANCY_EN
        check("post_rst_occupancy", occ[0], 3'd1);
`endif
        @(negedge clk);
        ins_valid[0]  = 1'b0;
        outs_ready[0] = 1'b1;
        @(negedge clk);
        outs_ready[0] = 1'b0;
        @(negedge clk);
        check("final_empty", outs_valid[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
